// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount through four coin hoppers (10, 5, 2, 1).
// Coins are paid greedily, largest first. Hoppers that are empty or fail to ack in
// time are skipped for the rest of the transaction. On completion a one-cycle done
// pulse is raised, paid holds the amount ejected and shortfall holds what could not
// be paid.
//
// Ports:
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   req_valid_i  change request valid
//   req_amount_i change amount to pay
//   req_ready_o  high only while idle; accept on req_valid_i & req_ready_o
//   hop_empty_i  per-hopper empty flags (bit3=10, bit2=5, bit1=2, bit0=1)
//   hop_sel_o    selected hopper (3=10, 2=5, 1=2, 0=1)
//   hop_fire_o   eject request, held until ack or timeout
//   hop_ack_i    hopper ejected a coin (only looked at while firing)
//   busy_o       high whenever not idle
//   done_o       one-cycle end-of-transaction pulse
//   paid_o       amount paid in the current/last transaction
//   shortfall_o  amount left unpaid in the last transaction
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid_i,
  input  logic [7:0] req_amount_i,
  output logic       req_ready_o,
  input  logic [3:0] hop_empty_i,
  output logic [1:0] hop_sel_o,
  output logic       hop_fire_o,
  input  logic       hop_ack_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] paid_o,
  output logic [7:0] shortfall_o
);

  localparam int unsigned TmoW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StPick, StFire, StGap, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [7:0]      paid_q, paid_d;
  logic [7:0]      shortfall_q, shortfall_d;
  logic [3:0]      fault_q, fault_d;
  logic [1:0]      sel_q, sel_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic            pick_ok;
  logic [1:0]      pick_idx;

  function automatic logic [7:0] denom(input logic [1:0] idx);
    logic [7:0] val;
    case (idx)
      2'd3:    val = 8'd10;
      2'd2:    val = 8'd5;
      2'd1:    val = 8'd2;
      default: val = 8'd1;
    endcase
    return val;
  endfunction

  // Denominations grow with the index, so the last qualifying index is the largest coin.
  // The d <= remaining test also keeps remaining from underflowing.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if ((denom(2'(i)) <= remaining_q) && !hop_empty_i[i] && !fault_q[i]) begin
        pick_ok  = 1'b1;
        pick_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    paid_d      = paid_q;
    shortfall_d = shortfall_q;
    fault_d     = fault_q;
    sel_d       = sel_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          remaining_d = req_amount_i;
          paid_d      = 8'd0;
          shortfall_d = 8'd0;
          fault_d     = 4'd0;
          state_d     = StPick;
        end
      end
      StPick: begin
        if (pick_ok) begin
          sel_d   = pick_idx;
          tmo_d   = '0;
          state_d = StFire;
        end else begin
          // Latched on the way into DONE so it is valid alongside the done pulse.
          shortfall_d = remaining_q;
          state_d     = StDone;
        end
      end
      StFire: begin
        // Ack takes priority over a timeout in the same cycle.
        if (hop_ack_i) begin
          remaining_d = remaining_q - denom(sel_q);
          paid_d      = paid_q + denom(sel_q);
          gap_d       = '0;
          state_d     = StGap;
        end else if (tmo_q == TmoLast) begin
          fault_d[sel_q] = 1'b1;
          state_d        = StPick;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StPick;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      remaining_q <= 8'd0;
      paid_q      <= 8'd0;
      shortfall_q <= 8'd0;
      fault_q     <= 4'd0;
      sel_q       <= 2'd0;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      paid_q      <= paid_d;
      shortfall_q <= shortfall_d;
      fault_q     <= fault_d;
      sel_q       <= sel_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign hop_fire_o  = (state_q == StFire);
  assign done_o      = (state_q == StDone);
  assign hop_sel_o   = sel_q;
  assign paid_o      = paid_q;
  assign shortfall_o = shortfall_q;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending-machine FSM. It takes the change amount the vending FSM computes and pays it out through four coin hoppers (values 10, 5, 2, 1). It pays greedily, largest coin first, and skips hoppers that are empty or stop responding. When finished it reports the amount paid and any amount it could not pay.

## Interface
Parameters:
- ACK_TIMEOUT, 64: max cycles hop_fire waits for hop_ack before the hopper is marked faulty; ≥2.
- GAP_CYCLES, 2: idle cycles between coins (hopper recovery); ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  change request valid.
- req_amount  in  8  change to pay, unsigned.
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready at clk edge.
- hop_empty  in  4  per-hopper empty flag; bit3=10, bit2=5, bit1=2, bit0=1.
- hop_sel  out  2  selected hopper: 3=10, 2=5, 1=2, 0=1.
- hop_fire  out  1  eject-one-coin request, held until ack or timeout.
- hop_ack  in  1  hopper ejected the coin; sampled only in FIRE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- paid  out  8  total paid in the last transaction.
- shortfall  out  8  amount left unpaid in the last transaction.

## Operation
Internal registers:
- remaining (8b)
- paid (8b)
- fault mask (4b), cleared on accept
- timeout counter
- gap counter

States:
- IDLE: req_ready=1. On accept: remaining←req_amount, paid←0, shortfall←0, fault←0 → PICK.
- PICK: selects the largest denomination d with d ≤ remaining, !hop_empty[i], !fault[i]; hop_sel←i → FIRE. If remaining==0 or no hopper qualifies → DONE. hop_empty is sampled in PICK only; a change during FIRE does not matter.
- FIRE: hop_fire=1, hop_sel stable, timeout counter increments each cycle from 0.
  - hop_ack=1: remaining←remaining−d, paid←paid+d → GAP.
  - Counter reaches ACK_TIMEOUT−1 with no ack: fault[i]←1 → PICK.
  - Ack and timeout in the same cycle: ack wins.
- GAP: hop_fire=0 for GAP_CYCLES cycles → PICK.
- DONE: done=1, shortfall←remaining → IDLE.

Arithmetic:
- Greedy choice with the d ≤ remaining check means remaining never underflows.
- paid + remaining == req_amount holds at every cycle of a transaction.

Output holding:
- paid and shortfall hold their values from DONE until the next accept.
- hop_ack outside FIRE is ignored.
- req_valid while busy is ignored; the upstream FSM must hold the request until req_ready.

## Timing
- Reset values (async):
  - state IDLE
  - req_ready=1 (Moore output of IDLE)
  - hop_fire=0, hop_sel=0
  - busy=0, done=0
  - paid=0, shortfall=0
  - counters and fault mask 0
- All outputs are Moore, decoded from registered state/regs; no combinational input→output path.
- Accept at edge T: busy=1 and PICK from T; hop_fire=1 from edge T+1 at the earliest.
- Per coin with ack in the k-th FIRE cycle: 1 (PICK) + k + GAP_CYCLES cycles.
- Zero amount: accept at T, PICK T, DONE T+1, done high for the cycle after edge T+1, IDLE after edge T+2.
- Timeout: hop_fire high for exactly ACK_TIMEOUT cycles, then low for ≥1 cycle (PICK).
- Reset asserted mid-transaction: hop_fire drops immediately (async). The transaction is abandoned with no done pulse; paid and shortfall read 0.

## Test plan
- req_amount=18, all hoppers ok, ack 1 cycle after fire → hop_sel sequence 3,2,1,0; done with paid=18, shortfall=0; hop_fire low ≥GAP_CYCLES between coins.
- req_amount=0 → no hop_fire; done exactly two cycles after accept; paid=0, shortfall=0; req_ready low only during the transaction.
- hop_empty=4'b1000, req_amount=20 → four coins of 5 (hop_sel=2 ×4); paid=20, shortfall=0.
- req_amount=7, hopper 5 never acks → hop_fire on sel=2 for 64 cycles, then sels 1,1,1,0; paid=7, shortfall=0; a second request re-tries hopper 5 (fault mask cleared).
- hop_empty=4'b1111, req_amount=9 → no fire; done with paid=0, shortfall=9. Separately, hop_ack in the same cycle as timeout → counted as paid.
- rstn low mid-FIRE on req_amount=15 → hop_fire, busy, paid, shortfall all 0 immediately; after release, req_ready=1 and a new request of 3 pays sels 1,0.
